// File: rtl/serial_subtractor_fsm.sv
// Bit-serial N-bit r = a - b, LSB first, one bit per clock; done pulses N cycles after start with flags {Nf,Z,C,V}.
// Optional SUB_ADD_MODE_EN adds an op input (0 = add, 1 = subtract) latched alongside a/b.
module serial_subtractor_fsm #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef SUB_ADD_MODE_EN
  input  logic         op,
`endif
  output logic [N-1:0] r,
  output logic [3:0]   f,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q, sum_q, r_q;
  logic [3:0]     f_q;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  logic           sub_q;

  logic           a_bit, b_eff_bit, sum_bit, carry_nxt, last_bit, load;
  logic [N-1:0]   res_full;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Operands stay unshifted; the bit counter selects the current column.
  always_comb begin
    last_bit  = (cnt_q == CW'(N - 1));
    load      = start && (state_q != SHIFT);
    a_bit     = a_q[cnt_q];
    b_eff_bit = sub_q ? ~b_q[cnt_q] : b_q[cnt_q];
    sum_bit   = a_bit ^ b_eff_bit ^ carry_q;
    carry_nxt = (a_bit & b_eff_bit) | (carry_q & (a_bit ^ b_eff_bit));
    res_full  = {sum_bit, sum_q[N-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      r_q     <= '0;
      f_q     <= '0;
      carry_q <= 1'b1;
      cnt_q   <= '0;
      sub_q   <= 1'b1;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      cnt_q   <= '0;
`ifdef SUB_ADD_MODE_EN
      sub_q   <= op;
      carry_q <= op;
`else
      sub_q   <= 1'b1;
      carry_q <= 1'b1;
`endif
    end else if (state_q == SHIFT) begin
      sum_q   <= res_full;
      carry_q <= carry_nxt;
      cnt_q   <= cnt_q + CW'(1);
      // On the MSB column a_bit/b_eff_bit are the operand sign bits.
      if (last_bit) begin
        r_q <= res_full;
        f_q <= {sum_bit, (res_full == '0), carry_nxt,
                (a_bit == b_eff_bit) && (sum_bit != a_bit)};
      end
    end
  end

  assign r = r_q;
  assign f = f_q;

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// Randomized bench for serial_subtractor_fsm against an integer-arithmetic reference model.
module tb_serial_subtractor_fsm;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         op = 1'b1;
  logic [N-1:0] r;
  logic [3:0]   f;
  logic         busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] last_r = '0;
  logic [3:0]   last_f = '0;

  serial_subtractor_fsm #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SUB_ADD_MODE_EN
    .op    (op),
`endif
    .r     (r),
    .f     (f),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {r, Nf, Z, C, V} from plain integer arithmetic.
  function automatic logic [N+3:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic is_sub);
    int ux, uy, sx, sy, md, res, sres;
    logic c, v;
    logic [N-1:0] rr;
    md = 1 << N;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= md / 2) ? ux - md : ux;
    sy = (uy >= md / 2) ? uy - md : uy;
    if (is_sub) begin
      res  = ux - uy;
      sres = sx - sy;
      c    = (ux >= uy);
    end else begin
      res  = ux + uy;
      sres = sx + sy;
      c    = (res >= md);
    end
    rr = res[N-1:0];
    v  = (sres < -(md / 2)) || (sres >= md / 2);
    return {rr, rr[N-1], (rr == '0), c, v};
  endfunction

  // Called at a negedge; returns at the negedge where done is expected.
  task automatic op_run(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                        input logic top, input bit glitch);
    logic [N+3:0] exp;
    exp   = model(ta, tb_v, top);
    a     = ta;
    b     = tb_v;
    op    = top;
    start = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("busy_shift", busy, 1'b1);
      check("done_shift", done, 1'b0);
      check("r_hold", r, last_r);
      check("f_hold", f, last_f);
      a     = N'($urandom);
      b     = N'($urandom);
      op    = 1'($urandom);
      start = (glitch && i == 1);
    end
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("r_result", r, exp[N+3:4]);
    check("f_result", f, exp[3:0]);
    last_r = exp[N+3:4];
    last_f = exp[3:0];
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("done_low", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("r_held", r, last_r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic rand_op;
    repeat (2) @(negedge clk);
    check("rst_r", r, 4'b0000);
    check("rst_f", f, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    op_run(4'b1001, 4'b0101, 1'b1, 1'b0);
    idle_check();
    op_run(4'b0001, 4'b0001, 1'b1, 1'b0);
    check("dir_eq_r", r, 4'b0000);
    check("dir_eq_f", f, 4'b0110);
    idle_check();
    op_run(4'b0001, 4'b0010, 1'b1, 1'b0);
    check("dir_borrow_r", r, 4'b1111);
    check("dir_borrow_f", f, 4'b1000);
    // Back-to-back launch from the done cycle.
    op_run(4'b1000, 4'b0001, 1'b1, 1'b0);
    check("dir_ovf_r", r, 4'b0111);
    check("dir_ovf_f", f, 4'b0011);
    idle_check();
    // Start pulsed mid-operation with new operands must be ignored.
    op_run(4'b0110, 4'b0011, 1'b1, 1'b1);
    idle_check();
    op_run(4'b0000, 4'b1000, 1'b1, 1'b0);
    idle_check();
`ifdef SUB_ADD_MODE_EN
    op_run(4'b1111, 4'b0001, 1'b0, 1'b0);
    check("dir_add_r", r, 4'b0000);
    check("dir_add_f", f, 4'b0110);
    idle_check();
`endif

    for (int k = 0; k < 150; k++) begin
`ifdef SUB_ADD_MODE_EN
      rand_op = 1'($urandom);
`else
      rand_op = 1'b1;
`endif
      op_run(N'($urandom), N'($urandom), rand_op, bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    // Asynchronous reset in the middle of an operation.
    a     = 4'b0111;
    b     = 4'b0010;
    op    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_r", r, 4'b0000);
    check("arst_f", f, 4'b0000);
    @(negedge clk);
    rst    = 1'b0;
    last_r = '0;
    last_f = '0;
    @(negedge clk);
    op_run(4'b0101, 4'b0011, 1'b1, 1'b0);
    check("post_rst_r", r, 4'b0010);
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
